// File: rtl/sd_emmc_axi_pkg.sv
// Shared constants and FSM encodings for the eMMC DMA AXI burst responder.
package sd_emmc_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DMA_BURST_LEN   = 16;
    localparam int DMA_BURST_BYTES = 64;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sd_emmc_resp_ram.sv
// One-write / one-read synchronous word RAM with byte enables and a registered read port.
module sd_emmc_resp_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clock,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_be,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_d, rd_data_q;

    // A read of the word being written in the same cycle returns the old contents.
    always_comb begin
        rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
    end

    // NOTE: the storage array and its read register carry no reset; a reset loop over
    // every word would prevent mapping onto block RAM, and contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sd_emmc_axi_burst_responder.sv
// AXI4 burst slave backed by a word RAM: system-memory stand-in for the eMMC DMA
// master, with programmable back-pressure, decode errors and write-length checking.
module sd_emmc_axi_burst_responder
    import sd_emmc_axi_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DATA_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    input  logic                s_wlast,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [31:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    input  logic                stall_wr,
    input  logic                stall_rd,
    output logic                proto_err,
    output logic [15:0]         wr_beats,
    output logic [15:0]         rd_beats
);

    localparam logic [31:0]       WIN_BYTES = 32'd4 << MEM_AW;
    localparam logic [MEM_AW-1:0] IDX_ONE   = MEM_AW'(1);

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 2);
    endfunction

    // Unsigned offset compare covers both "below base" (wraps large) and "above top".
    function automatic logic out_of_window(input logic [31:0] addr);
        return (addr - BASE_ADDR) >= WIN_BYTES;
    endfunction

    wr_state_e         w_state_d, w_state_q;
    logic [MEM_AW-1:0] w_idx_d, w_idx_q;
    logic [7:0]        w_len_d, w_len_q;
    logic [8:0]        w_cnt_d, w_cnt_q;
    logic              w_dec_d, w_dec_q;
    logic              w_err_d, w_err_q;
    logic              proto_err_d, proto_err_q;
    logic [15:0]       wr_beats_d, wr_beats_q;

    rd_state_e         r_state_d, r_state_q;
    logic [MEM_AW-1:0] r_idx_d, r_idx_q;
    logic [7:0]        r_len_d, r_len_q;
    logic [7:0]        r_cnt_d, r_cnt_q;
    logic              r_dec_d, r_dec_q;
    logic [15:0]       rd_beats_d, rd_beats_q;

    logic              aw_hs, w_hs, ar_hs, r_hs, w_len_hit, r_last;
    logic              ram_wr_en, ram_rd_en;
    logic [MEM_AW-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    assign aw_hs     = (w_state_q == W_IDLE) && s_awvalid && !stall_wr;
    assign w_hs      = (w_state_q == W_DATA) && s_wvalid && !stall_wr;
    assign ar_hs     = (r_state_q == R_IDLE) && s_arvalid && !stall_rd;
    assign r_hs      = (r_state_q == R_DATA) && s_rready && !stall_rd;
    assign w_len_hit = (w_cnt_q == {1'b0, w_len_q});
    assign r_last    = (r_cnt_q == r_len_q);

    // NOTE: every next-state signal gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_dec_d     = w_dec_q;
        w_err_d     = w_err_q;
        proto_err_d = 1'b0;
        wr_beats_d  = wr_beats_q;
        ram_wr_en   = 1'b0;
        case (w_state_q)
            W_IDLE: if (aw_hs) begin
                w_idx_d   = word_idx(s_awaddr);
                w_len_d   = s_awlen;
                w_cnt_d   = '0;
                w_dec_d   = out_of_window(s_awaddr);
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                ram_wr_en  = !w_dec_q && (w_cnt_q <= {1'b0, w_len_q});
                w_idx_d    = w_idx_q + IDX_ONE;
                w_cnt_d    = w_cnt_q[8] ? w_cnt_q : w_cnt_q + 9'd1;
                wr_beats_d = wr_beats_q + 16'd1;
                // wlast early, late, or missing at the final beat: flag once per burst.
                if ((s_wlast != w_len_hit) && !w_err_q) begin
                    proto_err_d = 1'b1;
                    w_err_d     = 1'b1;
                end
                if (s_wlast) w_state_d = W_RESP;
            end
            W_RESP: if (s_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_len_d    = r_len_q;
        r_cnt_d    = r_cnt_q;
        r_dec_d    = r_dec_q;
        rd_beats_d = rd_beats_q;
        case (r_state_q)
            R_IDLE: if (ar_hs) begin
                r_idx_d   = word_idx(s_araddr);
                r_len_d   = s_arlen;
                r_cnt_d   = '0;
                r_dec_d   = out_of_window(s_araddr);
                r_state_d = R_DATA;
            end
            R_DATA: if (r_hs) begin
                r_idx_d    = r_idx_q + IDX_ONE;
                r_cnt_d    = r_cnt_q + 8'd1;
                rd_beats_d = rd_beats_q + 16'd1;
                if (r_last) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // The read register only reloads on a handshake, which keeps rdata stable under stalls.
    assign ram_rd_en   = ar_hs || r_hs;
    assign ram_rd_addr = (r_state_q == R_IDLE) ? word_idx(s_araddr) : r_idx_q + IDX_ONE;

    sd_emmc_resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
        .clock   (clock),
        .wr_en   (ram_wr_en),
        .wr_addr (w_idx_q),
        .wr_data (s_wdata),
        .wr_be   (s_wstrb),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            w_dec_q     <= 1'b0;
            w_err_q     <= 1'b0;
            proto_err_q <= 1'b0;
            wr_beats_q  <= '0;
            r_state_q   <= R_IDLE;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_cnt_q     <= '0;
            r_dec_q     <= 1'b0;
            rd_beats_q  <= '0;
        end else begin
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_cnt_q     <= w_cnt_d;
            w_dec_q     <= w_dec_d;
            w_err_q     <= w_err_d;
            proto_err_q <= proto_err_d;
            wr_beats_q  <= wr_beats_d;
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_cnt_q     <= r_cnt_d;
            r_dec_q     <= r_dec_d;
            rd_beats_q  <= rd_beats_d;
        end
    end

    assign s_awready = (w_state_q == W_IDLE) && !stall_wr && !reset;
    assign s_wready  = (w_state_q == W_DATA) && !stall_wr;
    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = (s_bvalid && (w_dec_q || w_err_q)) ? RESP_SLVERR : RESP_OKAY;
    assign s_arready = (r_state_q == R_IDLE) && !stall_rd && !reset;
    assign s_rvalid  = (r_state_q == R_DATA) && !stall_rd;
    assign s_rlast   = (r_state_q == R_DATA) && r_last;
    assign s_rresp   = ((r_state_q == R_DATA) && r_dec_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_rdata   = ((r_state_q == R_DATA) && !r_dec_q) ? ram_rd_data : '0;
    assign proto_err = proto_err_q;
    assign wr_beats  = wr_beats_q;
    assign rd_beats  = rd_beats_q;

endmodule

// File: tb/tb_sd_emmc_axi_burst_responder.sv
// Directed self-checking bench for sd_emmc_axi_burst_responder: bursts, strobes,
// back-pressure, protocol and decode errors, and wrap with concurrent read/write.
module tb_sd_emmc_axi_burst_responder;
    import sd_emmc_axi_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_awaddr = '0;
    logic [7:0]  s_awlen = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wlast = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic        stall_wr = 1'b0;
    logic        stall_rd = 1'b0;
    logic        proto_err;
    logic [15:0] wr_beats;
    logic [15:0] rd_beats;

    int errors = 0;
    int checks = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    logic [31:0] rd_buf      [256];
    logic [1:0]  rd_resp_buf [256];
    logic        rd_last_buf [256];
    int          rd_n;
    logic [1:0]  last_bresp;
    int          perr_cnt;

    sd_emmc_axi_burst_responder #(
        .MEM_AW(10), .BASE_ADDR(32'h0000_0000), .DATA_W(32)
    ) dut (
        .clock(clock), .reset(reset),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .stall_wr(stall_wr), .stall_rd(stall_rd),
        .proto_err(proto_err), .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    always #5 clock = ~clock;

    // Write burst of nbeats with wlast on the final one; data = base + beat.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                               input logic [31:0] base, input logic [3:0] strb);
        bit got;
        bit timed_out;
        timed_out  = 1'b0;
        perr_cnt   = 0;
        last_bresp = 2'bxx;
        s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock); got = s_awready; @(posedge clock); #1;
        end
        s_awvalid = 1'b0;
        if (!got) timed_out = 1'b1;
        for (int b = 0; b < nbeats && !timed_out; b++) begin
            s_wdata = base + 32'(b); s_wstrb = strb; s_wlast = (b == nbeats - 1); s_wvalid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clock);
                if (proto_err) perr_cnt++;
                got = s_wready;
                @(posedge clock); #1;
            end
            if (got) exp_wr++; else timed_out = 1'b1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got && !timed_out; t++) begin
            @(negedge clock);
            if (proto_err) perr_cnt++;
            if (s_bvalid) begin got = 1'b1; last_bresp = s_bresp; end
            @(posedge clock); #1;
        end
        s_bready = 1'b0;
        if (!got) timed_out = 1'b1;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL write_timeout addr=%h: handshake not completed, required completion", addr);
        end
    endtask

    // Read burst; with toggle set, stall_rd flips every 3 cycles and rready every 2.
    // Any cycle without a handshake must leave rdata/rlast unchanged on the next one.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        bit got;
        bit done;
        bit have_prev;
        logic [31:0] prev_d;
        logic        prev_l;
        rd_n = 0;
        s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock); got = s_arready; @(posedge clock); #1;
        end
        s_arvalid = 1'b0;
        done = !got;
        have_prev = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            stall_rd = toggle ? (((cyc / 3) % 2) == 1) : 1'b0;
            s_rready = toggle ? (((cyc / 2) % 2) == 0) : 1'b1;
            @(negedge clock);
            if (have_prev) begin
                checks++;
                if (s_rdata !== prev_d || s_rlast !== prev_l) begin
                    errors++;
                    $display("FAIL rd_stable cyc=%0d: rdata=%h rlast=%b, required %h %b",
                             cyc, s_rdata, s_rlast, prev_d, prev_l);
                end
            end
            if (s_rvalid && s_rready) begin
                rd_buf[rd_n] = s_rdata; rd_resp_buf[rd_n] = s_rresp; rd_last_buf[rd_n] = s_rlast;
                rd_n++; exp_rd++;
                if (s_rlast || rd_n == 256) done = 1'b1;
                have_prev = 1'b0;
            end else begin
                have_prev = 1'b1; prev_d = s_rdata; prev_l = s_rlast;
            end
            @(posedge clock); #1;
        end
        stall_rd = 1'b0; s_rready = 1'b0;
        checks++;
        if (rd_n != int'(len) + 1) begin
            errors++;
            $display("FAIL rd_beat_count addr=%h: got %0d beats, required %0d", addr, rd_n, int'(len) + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, proto_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: aw/w/b/ar/r/rlast/perr=%b, required 0000000",
                     {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast, proto_err});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata, wr_beats, rd_beats} !== '0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h wr=%0d rd=%0d, required all 0",
                     s_bresp, s_rresp, s_rdata, wr_beats, rd_beats);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (s_awready !== 1'b1 || s_arready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: awready=%b arready=%b, required 1 1", s_awready, s_arready);
        end
        stall_wr = 1'b1; stall_rd = 1'b1;
        #1;
        checks++;
        if (s_awready !== 1'b0 || s_arready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: awready=%b arready=%b, required 0 0", s_awready, s_arready);
        end
        stall_wr = 1'b0; stall_rd = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic_burst();
        write_burst(32'h40, 8'd15, DMA_BURST_LEN, 32'h0, 4'hF);
        checks++;
        if (last_bresp !== RESP_OKAY) begin
            errors++; $display("FAIL basic_bresp: got %b, required 00", last_bresp);
        end
        read_burst(32'h40, 8'd15, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'(i) || rd_last_buf[i] !== (i == 15) || rd_resp_buf[i] !== RESP_OKAY) begin
                errors++;
                $display("FAIL basic_beat%0d: data=%h last=%b resp=%b, required %h %b 00",
                         i, rd_buf[i], rd_last_buf[i], rd_resp_buf[i], 32'(i), (i == 15));
            end
        end
        checks++;
        if (wr_beats !== 16'd16 || rd_beats !== 16'd16) begin
            errors++;
            $display("FAIL basic_counters: wr=%0d rd=%0d, required 16 16", wr_beats, rd_beats);
        end
    endtask

    task automatic test_stall_read();
        read_burst(32'h40, 8'd15, 1'b1);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'(i) || rd_last_buf[i] !== (i == 15)) begin
                errors++;
                $display("FAIL stall_beat%0d: data=%h last=%b, required %h %b",
                         i, rd_buf[i], rd_last_buf[i], 32'(i), (i == 15));
            end
        end
    endtask

    task automatic test_strobe();
        write_burst(32'h100, 8'd0, 1, 32'h0, 4'hF);
        write_burst(32'h100, 8'd0, 1, 32'hAABB_CCDD, 4'b0101);
        read_burst(32'h100, 8'd0, 1'b0);
        checks++;
        if (rd_buf[0] !== 32'h00BB_00DD || rd_last_buf[0] !== 1'b1) begin
            errors++;
            $display("FAIL strobe_merge: data=%h last=%b, required 00bb00dd 1", rd_buf[0], rd_last_buf[0]);
        end
    endtask

    task automatic test_proto_err();
        write_burst(32'h200, 8'd15, 16, 32'hEEEE_0000, 4'hF);
        checks++;
        if (perr_cnt != 0 || last_bresp !== RESP_OKAY) begin
            errors++;
            $display("FAIL proto_clean: pulses=%0d bresp=%b, required 0 00", perr_cnt, last_bresp);
        end
        write_burst(32'h200, 8'd15, 10, 32'h0000_5000, 4'hF);
        checks++;
        if (perr_cnt != 1 || last_bresp !== RESP_SLVERR) begin
            errors++;
            $display("FAIL proto_early_wlast: pulses=%0d bresp=%b, required 1 10", perr_cnt, last_bresp);
        end
        read_burst(32'h200, 8'd15, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            logic [31:0] exp_d;
            exp_d = (i < 10) ? 32'h0000_5000 + 32'(i) : 32'hEEEE_0000 + 32'(i);
            checks++;
            if (rd_buf[i] !== exp_d) begin
                errors++;
                $display("FAIL proto_word%0d: got %h, required %h", i, rd_buf[i], exp_d);
            end
        end
    endtask

    task automatic test_wrap_concurrent();
        write_burst(32'hFF0, 8'd15, 16, 32'h1000_0000, 4'hF);
        fork
            write_burst(32'hFF0, 8'd15, 16, 32'h2000_0000, 4'hF);
            read_burst(32'hFF0, 8'd15, 1'b0);
        join
        checks++;
        if (last_bresp !== RESP_OKAY || perr_cnt != 0) begin
            errors++;
            $display("FAIL wrap_bresp: bresp=%b pulses=%0d, required 00 0", last_bresp, perr_cnt);
        end
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h1000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_old%0d: got %h, required %h", i, rd_buf[i], 32'h1000_0000 + 32'(i));
            end
        end
        read_burst(32'hFF0, 8'd15, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h2000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_new%0d: got %h, required %h", i, rd_buf[i], 32'h2000_0000 + 32'(i));
            end
        end
        read_burst(32'h0, 8'd11, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h2000_0004 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_low%0d: got %h, required %h", i, rd_buf[i], 32'h2000_0004 + 32'(i));
            end
        end
    endtask

    task automatic test_decode_err();
        write_burst(32'h1000, 8'd15, 16, 32'hDEAD_0000, 4'hF);
        checks++;
        if (last_bresp !== RESP_SLVERR) begin
            errors++; $display("FAIL decode_bresp: got %b, required 10", last_bresp);
        end
        read_burst(32'h0, 8'd11, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h2000_0004 + 32'(i)) begin
                errors++;
                $display("FAIL decode_ram%0d: got %h, required %h", i, rd_buf[i], 32'h2000_0004 + 32'(i));
            end
        end
        read_burst(32'h1000, 8'd15, 1'b0);
        for (int i = 0; i < rd_n; i++) begin
            checks++;
            if (rd_buf[i] !== 32'h0 || rd_resp_buf[i] !== RESP_SLVERR || rd_last_buf[i] !== (i == 15)) begin
                errors++;
                $display("FAIL decode_rd%0d: data=%h resp=%b last=%b, required 00000000 10 %b",
                         i, rd_buf[i], rd_resp_buf[i], rd_last_buf[i], (i == 15));
            end
        end
        checks++;
        if (wr_beats !== 16'(exp_wr) || rd_beats !== 16'(exp_rd)) begin
            errors++;
            $display("FAIL total_counters: wr=%0d rd=%0d, required %0d %0d", wr_beats, rd_beats, exp_wr, exp_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_stall_read();
        test_strobe();
        test_proto_err();
        test_wrap_concurrent();
        test_decode_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
